// File: rtl/aht20_i2c_responder_if.sv
// Two-wire I2C bus between an initiator and the AHT20 responder.
// SDA is open-drain: every agent drives 0 or 'z', the pull-up supplies the 1.
interface aht20_i2c_responder_if;
    logic SCL;
    wire  SDA;

    pullup (SDA);

    modport master (output SCL, inout SDA);
    modport slave  (input SCL, inout SDA);
endinterface

// File: rtl/aht20_i2c_responder.sv
// I2C target emulating an AHT20 sensor: decodes init/trigger/soft-reset writes
// and serves the 6-byte status + humidity + temperature read frame.
module aht20_i2c_responder #(
    parameter logic [6:0]  ADDRESS        = 7'h38,
    parameter int unsigned MEASURE_CYCLES = 4_000_000
) (
    input  logic                        clock,
    input  logic                        reset,
    aht20_i2c_responder_if.slave        bus,
    input  logic [19:0]                 hum_value,
    input  logic [19:0]                 temp_value,
    output logic                        measure_busy,
    output logic                        calibrated,
    output logic [7:0]                  last_cmd,
    output logic [3:0]                  debug_state
);
    localparam int CW = $clog2(MEASURE_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        WR_BYTE   = 4'd3,
        WR_ACK    = 4'd4,
        RD_BYTE   = 4'd5,
        RD_ACK    = 4'd6,
        WAIT_STOP = 4'd7
    } state_t;

    state_t          state;
    logic [1:0]      scl_sync, sda_sync;
    logic            scl_prev, sda_prev;
    logic [3:0]      bit_cnt;
    logic [7:0]      shift;
    logic            rw;
    logic [1:0]      wr_idx;
    logic            wr_over;
    logic [7:0]      wr0, wr1, wr2;
    logic [2:0]      rd_idx;
    logic [7:0]      tx_shift;
    logic            sda_low;
    logic [CW-1:0]   cnt;
    logic [19:0]     hum_q, temp_q;
    logic [7:0]      frame_byte;

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic write_complete, cmd_init, cmd_trig, cmd_reset;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    // A STOP is preceded by one SCL high with SDA low, which the byte shifter
    // clocks in as a single 0 bit; that still counts as a clean byte boundary.
    assign write_complete = (state == WR_BYTE) && !wr_over &&
                            ((bit_cnt == 4'd0) || (bit_cnt == 4'd1 && !shift[0]));
    assign cmd_init  = (wr_idx == 2'd3) && (wr0 == 8'hBE) && (wr1 == 8'h08) && (wr2 == 8'h00);
    assign cmd_trig  = (wr_idx == 2'd3) && (wr0 == 8'hAC) && (wr1 == 8'h33) && (wr2 == 8'h00);
    assign cmd_reset = (wr_idx == 2'd1) && (wr0 == 8'hBA);

    assign bus.SDA     = sda_low ? 1'b0 : 1'bz;
    assign debug_state = state;

    always_comb begin
        frame_byte = 8'hFF;
        case (rd_idx)
            3'd0: frame_byte = {measure_busy, 3'b000, calibrated, 3'b000};
            3'd1: frame_byte = hum_q[19:12];
            3'd2: frame_byte = hum_q[11:4];
            3'd3: frame_byte = {hum_q[3:0], temp_q[19:16]};
            3'd4: frame_byte = temp_q[15:8];
            3'd5: frame_byte = temp_q[7:0];
            default: frame_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            scl_sync     <= 2'b11;
            sda_sync     <= 2'b11;
            scl_prev     <= 1'b1;
            sda_prev     <= 1'b1;
            bit_cnt      <= '0;
            shift        <= '0;
            rw           <= 1'b0;
            wr_idx       <= '0;
            wr_over      <= 1'b0;
            wr0          <= '0;
            wr1          <= '0;
            wr2          <= '0;
            rd_idx       <= '0;
            tx_shift     <= '0;
            sda_low      <= 1'b0;
            cnt          <= '0;
            hum_q        <= '0;
            temp_q       <= '0;
            measure_busy <= 1'b0;
            calibrated   <= 1'b0;
            last_cmd     <= '0;
        end else begin
            scl_sync <= {scl_sync[0], bus.SCL};
            sda_sync <= {sda_sync[0], bus.SDA};
            scl_prev <= scl_s;
            sda_prev <= sda_s;

            if (measure_busy) begin
                if (cnt <= CW'(1)) begin
                    measure_busy <= 1'b0;
                    cnt          <= '0;
                    hum_q        <= hum_value;
                    temp_q       <= temp_value;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end

            if (stop_det) begin
                state   <= IDLE;
                sda_low <= 1'b0;
                if (write_complete) begin
                    if (cmd_init) begin
                        calibrated <= 1'b1;
                        last_cmd   <= 8'hBE;
                    end else if (cmd_trig && calibrated && !measure_busy) begin
                        measure_busy <= 1'b1;
                        cnt          <= CW'(MEASURE_CYCLES);
                        last_cmd     <= 8'hAC;
                    end else if (cmd_reset) begin
                        calibrated   <= 1'b0;
                        measure_busy <= 1'b0;
                        cnt          <= '0;
                        last_cmd     <= 8'hBA;
                    end
                end
            end else if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                wr_idx  <= '0;
                wr_over <= 1'b0;
                rd_idx  <= '0;
                sda_low <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift <= {shift[6:0], sda_s};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (shift[6:0] == ADDRESS) begin
                                rw    <= sda_s;
                                state <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    // sda_low doubles as the "ACK already driven" marker
                    ADDR_ACK: if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low <= 1'b1;
                        end else if (rw) begin
                            state    <= RD_BYTE;
                            bit_cnt  <= '0;
                            sda_low  <= ~frame_byte[7];
                            tx_shift <= {frame_byte[6:0], 1'b0};
                        end else begin
                            state   <= WR_BYTE;
                            bit_cnt <= '0;
                            sda_low <= 1'b0;
                        end
                    end
                    WR_BYTE: if (scl_rise) begin
                        shift <= {shift[6:0], sda_s};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            state   <= WR_ACK;
                            case (wr_idx)
                                2'd0:    wr0 <= {shift[6:0], sda_s};
                                2'd1:    wr1 <= {shift[6:0], sda_s};
                                2'd2:    wr2 <= {shift[6:0], sda_s};
                                default: wr_over <= 1'b1;
                            endcase
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    WR_ACK: if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low <= 1'b1;
                        end else begin
                            sda_low <= 1'b0;
                            state   <= WR_BYTE;
                            if (wr_idx != 2'd3) wr_idx <= wr_idx + 2'd1;
                        end
                    end
                    RD_BYTE: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                sda_low  <= ~frame_byte[7];
                                tx_shift <= {frame_byte[6:0], 1'b0};
                            end else if (bit_cnt == 4'd8) begin
                                sda_low <= 1'b0;
                                state   <= RD_ACK;
                            end else begin
                                sda_low  <= ~tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: if (scl_rise) begin
                        if (!sda_s) begin
                            if (rd_idx != 3'd6) rd_idx <= rd_idx + 3'd1;
                            bit_cnt <= '0;
                            state   <= RD_BYTE;
                        end else begin
                            state <= WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aht20_i2c_responder.sv
// Bench for aht20_i2c_responder: a bit-banged I2C initiator plus a
// command-level model of the sensor that predicts status, frame bytes and outputs.
module tb_aht20_i2c_responder;
    localparam int          Q    = 8;
    localparam int          MEAS = 3000;
    localparam logic [6:0]  ADR  = 7'h38;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] hum_value = '0;
    logic [19:0] temp_value = '0;
    logic        measure_busy, calibrated;
    logic [7:0]  last_cmd;
    logic [3:0]  debug_state;
    logic        m_low = 1'b0;
    logic        sda_line;

    int tests = 0;
    int fails = 0;

    aht20_i2c_responder_if bus ();
    assign bus.SDA  = m_low ? 1'b0 : 1'bz;
    assign sda_line = bus.SDA;

    aht20_i2c_responder #(.ADDRESS(ADR), .MEASURE_CYCLES(MEAS)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .hum_value    (hum_value),
        .temp_value   (temp_value),
        .measure_busy (measure_busy),
        .calibrated   (calibrated),
        .last_cmd     (last_cmd),
        .debug_state  (debug_state)
    );

    always #5 clock = ~clock;

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "simulation time limit reached");
    end

    // sensor model
    logic        m_cal = 1'b0, m_busy = 1'b0;
    logic [19:0] m_hum = '0, m_temp = '0;
    logic [7:0]  m_last = '0;
    logic [7:0]  txq[$];

    function automatic logic [7:0] model_frame(input int idx);
        logic [39:0] data;
        data = {m_hum, m_temp};
        if (idx == 0) return {m_busy, 3'b000, m_cal, 3'b000};
        if (idx <= 5) return 8'(data >> (8 * (5 - idx)));
        return 8'hFF;
    endfunction

    task automatic model_stop();
        if (txq.size() == 3 && txq[0] == 8'hBE && txq[1] == 8'h08 && txq[2] == 8'h00) begin
            m_cal = 1'b1; m_last = 8'hBE;
        end else if (txq.size() == 3 && txq[0] == 8'hAC && txq[1] == 8'h33 && txq[2] == 8'h00) begin
            if (m_cal && !m_busy) begin m_busy = 1'b1; m_last = 8'hAC; end
        end else if (txq.size() == 1 && txq[0] == 8'hBA) begin
            m_cal = 1'b0; m_busy = 1'b0; m_last = 8'hBA;
        end
    endtask

    task automatic model_settle();
        if (m_busy) begin
            m_busy = 1'b0; m_hum = hum_value; m_temp = temp_value;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
            $error("%s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // initiator driver
    task automatic bus_start();
        m_low = 1'b0;  wait_clk(Q);
        bus.SCL = 1'b1; wait_clk(Q);
        m_low = 1'b1;  wait_clk(Q);
        bus.SCL = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1;  wait_clk(Q);
        bus.SCL = 1'b1; wait_clk(Q);
        m_low = 1'b0;  wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = !b;    wait_clk(Q);
        bus.SCL = 1'b1; wait_clk(2 * Q);
        bus.SCL = 1'b0; wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0;  wait_clk(Q);
        bus.SCL = 1'b1; wait_clk(Q);
        b = sda_line;  wait_clk(Q);
        bus.SCL = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] v, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin recv_bit(b); v[i] = b; end
        send_bit(nack);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_cal"},  calibrated,   m_cal);
        check({tag, "_busy"}, measure_busy, m_busy);
        check({tag, "_last"}, last_cmd,     m_last);
    endtask

    task automatic do_write(input string tag);
        logic a;
        bus_start();
        send_byte({ADR, 1'b0}, a);
        check({tag, "_addr_ack"}, a, 1'b0);
        foreach (txq[i]) begin
            send_byte(txq[i], a);
            check($sformatf("%s_ack%0d", tag, i), a, 1'b0);
        end
        bus_stop();
        model_stop();
        wait_clk(8);
        check_outputs(tag);
    endtask

    task automatic do_read(input string tag, input int n);
        logic a;
        logic [7:0] v;
        bus_start();
        send_byte({ADR, 1'b1}, a);
        check({tag, "_addr_ack"}, a, 1'b0);
        for (int i = 0; i < n; i++) begin
            recv_byte(v, i == n - 1);
            check($sformatf("%s_byte%0d", tag, i), v, model_frame(i));
        end
        bus_stop();
    endtask

    initial begin
        int bad;
        logic a;
        logic [7:0] v;
        bus.SCL = 1'b1;

        // reset held while the bus toggles: SDA must stay released
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            bus.SCL = 1'($urandom_range(0, 1));
            m_low   = 1'($urandom_range(0, 1));
            wait_clk(1);
            if (!m_low && sda_line !== 1'b1) bad++;
        end
        check("reset_sda_released", bad, 0);
        check("reset_outputs", {measure_busy, calibrated, last_cmd, debug_state}, 14'h0);
        bus.SCL = 1'b1; m_low = 1'b0; wait_clk(4);
        reset = 1'b1;
        wait_clk(20);
        check("post_reset_sda", sda_line, 1'b1);
        check("post_reset_state", debug_state, 4'd0);

        // wrong address: NACK on address and on every following byte
        bus_start();
        send_byte({7'h39, 1'b0}, a);
        check("nack_0x39", a, 1'b1);
        send_byte(8'hBE, a); check("nack_0x39_d0", a, 1'b1);
        send_byte(8'h08, a); check("nack_0x39_d1", a, 1'b1);
        bus_stop();
        wait_clk(8);
        check_outputs("after_0x39");

        // init then status read
        txq = '{8'hBE, 8'h08, 8'h00};
        do_write("init");
        do_read("status", 1);

        // directed measurement
        hum_value = 20'h12345; temp_value = 20'hABCDE;
        txq = '{8'hAC, 8'h33, 8'h00};
        do_write("trig");
        do_read("busy_status", 1);
        wait_clk(MEAS + 50);
        model_settle();
        check("meas_done_busy", measure_busy, 1'b0);
        hum_value = 20'($urandom); temp_value = 20'($urandom);
        do_read("frame", 7);

        // randomized measurements: read while busy, then after completion
        for (int r = 0; r < 2; r++) begin
            hum_value = 20'($urandom); temp_value = 20'($urandom);
            txq = '{8'hAC, 8'h33, 8'h00};
            do_write($sformatf("rtrig%0d", r));
            do_read($sformatf("rbusy%0d", r), 6);
            txq = '{8'hAC, 8'h33, 8'h00};
            do_write($sformatf("rtrig_busy%0d", r));
            wait_clk(MEAS + 50);
            model_settle();
            hum_value = 20'($urandom); temp_value = 20'($urandom);
            do_read($sformatf("rdone%0d", r), 6);
        end

        // asynchronous reset mid-run clears everything, captured data included
        reset = 1'b0;
        wait_clk(3);
        check("midrst_outputs", {measure_busy, calibrated, last_cmd, debug_state}, 14'h0);
        reset = 1'b1;
        m_cal = 1'b0; m_busy = 1'b0; m_hum = '0; m_temp = '0; m_last = '0;
        wait_clk(10);

        txq = '{8'hAC, 8'h33, 8'h00};
        do_write("uncal_trig");
        do_read("cleared", 6);
        txq = '{8'hBE, 8'h08, 8'h00};
        do_write("init2");
        txq = '{8'hBA};
        do_write("softrst");
        txq = '{8'h71};
        do_write("status_cmd");
        txq = '{8'hBE, 8'h08, 8'h00, 8'h00};
        do_write("too_long");

        // random byte sequences through the same command rules
        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 4);
            txq.delete();
            for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
            do_write($sformatf("rand%0d", r));
        end

        // repeated START after two bytes of an init command
        bus_start();
        send_byte({ADR, 1'b0}, a);
        send_byte(8'hBE, a); check("sr_ack0", a, 1'b0);
        send_byte(8'h08, a); check("sr_ack1", a, 1'b0);
        bus_start();
        send_byte({ADR, 1'b1}, a);
        check("sr_read_ack", a, 1'b0);
        recv_byte(v, 1'b1);
        check("sr_status", v, model_frame(0));
        bus_stop();
        wait_clk(8);
        check_outputs("after_sr");

        // STOP in the middle of the third byte
        bus_start();
        send_byte({ADR, 1'b0}, a);
        send_byte(8'hBE, a);
        send_byte(8'h08, a);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        bus_stop();
        wait_clk(8);
        check_outputs("after_midstop");

        // normal decoding resumes
        txq = '{8'hBE, 8'h08, 8'h00};
        do_write("init3");
        do_read("status3", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
